// File: rtl/mul_seq_ctrl.sv
// Iterative shift-add multiply sequencer beside the EX-stage ALU; stalls the pipe while it runs.
// Define MUL_SEQ_HI_EN to widen the datapath to 64 bits and add result_hi_o (upper product word).
module mul_seq_ctrl #(
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter logic [2:0]  MUL_CODE       = 3'b111
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [2:0]  ALUCtrl_i,
  input  logic [31:0] data1_i,
  input  logic [31:0] data2_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic [31:0] result_o,
`ifdef MUL_SEQ_HI_EN
  output logic [31:0] result_hi_o,
`endif
  output logic        result_valid_o
);

  localparam int unsigned ITERS = 32 / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = 6;
`ifdef MUL_SEQ_HI_EN
  localparam int unsigned ACC_W = 64;
`else
  localparam int unsigned ACC_W = 32;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   mcand;
  logic [31:0]        mplier;
  logic [ACC_W-1:0]   partial;
  logic [ACC_W-1:0]   acc_next;
  logic               req;
  logic               last_iter;

  assign req       = valid_i && (ALUCtrl_i == MUL_CODE) && !flush_i;
  assign last_iter = (cnt == CNT_W'(ITERS - 1));
  assign acc_next  = acc + partial;
  assign busy_o    = (state != IDLE);

  // Multiplicand times the low BITS_PER_CYCLE multiplier bits, as a sum of shifted copies.
  always_comb begin
    partial = '0;
    for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
      if (mplier[i[4:0]]) partial = partial + (mcand << i);
    end
  end

  // Stall must rise in the request cycle itself and drop in a flush cycle, so it is combinational.
  always_comb begin
    stall_o = 1'b0;
    case (state)
      IDLE:    stall_o = req;
      RUN:     stall_o = !flush_i;
      default: stall_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state          <= IDLE;
      cnt            <= '0;
      acc            <= '0;
      mcand          <= '0;
      mplier         <= '0;
      result_o       <= '0;
`ifdef MUL_SEQ_HI_EN
      result_hi_o    <= '0;
`endif
      result_valid_o <= 1'b0;
    end else begin
      result_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            mcand  <= ACC_W'(data1_i);
            mplier <= data2_i;
            acc    <= '0;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          if (flush_i) begin
            acc   <= '0;
            cnt   <= '0;
            state <= IDLE;
          end else begin
            acc    <= acc_next;
            mcand  <= mcand << BITS_PER_CYCLE;
            mplier <= mplier >> BITS_PER_CYCLE;
            cnt    <= cnt + CNT_W'(1);
            if (last_iter) begin
              // Final sum is published on entry to DONE and held afterwards.
              result_o       <= acc_next[31:0];
`ifdef MUL_SEQ_HI_EN
              result_hi_o    <= acc_next[63:32];
`endif
              result_valid_o <= 1'b1;
              state          <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: one radix-2 and one radix-16 instance share the same stimulus.
module tb_mul_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [2:0]  code;
  logic [31:0] d1;
  logic [31:0] d2;
  logic        flush;

  logic        s1, b1, v1;
  logic [31:0] r1;
  logic        s4, b4, v4;
  logic [31:0] r4;
`ifdef MUL_SEQ_HI_EN
  logic [31:0] rh1, rh4;
`endif

  logic        sel4;
  logic        st, bz, rv;
  logic [31:0] rs;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] MUL = 3'b111;
  localparam logic [2:0] ADD = 3'b010;

  mul_seq_ctrl #(.BITS_PER_CYCLE(1), .MUL_CODE(MUL)) dut1 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .ALUCtrl_i(code),
    .data1_i(d1), .data2_i(d2), .flush_i(flush),
    .stall_o(s1), .busy_o(b1), .result_o(r1),
`ifdef MUL_SEQ_HI_EN
    .result_hi_o(rh1),
`endif
    .result_valid_o(v1)
  );

  mul_seq_ctrl #(.BITS_PER_CYCLE(4), .MUL_CODE(MUL)) dut4 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .ALUCtrl_i(code),
    .data1_i(d1), .data2_i(d2), .flush_i(flush),
    .stall_o(s4), .busy_o(b4), .result_o(r4),
`ifdef MUL_SEQ_HI_EN
    .result_hi_o(rh4),
`endif
    .result_valid_o(v4)
  );

  assign st = sel4 ? s4 : s1;
  assign bz = sel4 ? b4 : b1;
  assign rv = sel4 ? v4 : v1;
  assign rs = sel4 ? r4 : r1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one MUL in the next cycle, then watch the stall window and the result pulse.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input bit scramble, input int exp_stall, input logic [31:0] exp_res);
    int stalls;
    int vcyc;
    bit seen;
    logic [31:0] got;
    @(negedge clk);
    valid = 1'b1; code = MUL; d1 = a; d2 = b; flush = 1'b0;
    #1;
    check({tag, "_req_stall"}, 64'(st), 64'(1));
    stalls = 1; vcyc = 0; seen = 1'b0; got = '0;
    for (int c = 2; c <= 45 && !seen; c++) begin
      @(negedge clk);
      valid = 1'b0;
      if (scramble) begin
        d1 = $urandom;
        d2 = $urandom;
      end
      #1;
      if (c == 2) check({tag, "_busy_run"}, 64'(bz), 64'(1));
      if (st) stalls++;
      if (rv) begin
        seen = 1'b1;
        vcyc = c;
        got  = rs;
      end
    end
    check({tag, "_seen"}, 64'(seen), 64'(1));
    check({tag, "_stall_cycles"}, 64'(stalls), 64'(exp_stall));
    check({tag, "_valid_cycle"}, 64'(vcyc), 64'(exp_stall + 1));
    check({tag, "_result"}, 64'(got), 64'(exp_res));
  endtask

  task automatic post_idle(input string tag);
    @(negedge clk);
    valid = 1'b0;
    #1;
    check({tag, "_post_stall"}, 64'(st), 64'(0));
    check({tag, "_post_valid"}, 64'(rv), 64'(0));
    check({tag, "_post_busy"}, 64'(bz), 64'(0));
  endtask

  initial begin
    logic [2:0] codes [5];
    int vcount;
    codes[0] = 3'b000; codes[1] = 3'b001; codes[2] = 3'b010;
    codes[3] = 3'b110; codes[4] = 3'b100;

    sel4 = 1'b0;
    rst = 1'b0; valid = 1'b0; code = 3'b000; d1 = '0; d2 = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", 64'(st), 64'(0));
    check("rst_busy", 64'(bz), 64'(0));
    check("rst_valid", 64'(rv), 64'(0));
    check("rst_result", 64'(rs), 64'(0));
    rst = 1'b1;

    // Non-MUL codes pass straight through.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      valid = 1'b1; code = codes[i]; d1 = 32'd9; d2 = 32'd9;
      #1;
      check($sformatf("pass_stall_%0d", i), 64'(st), 64'(0));
    end
    @(negedge clk);
    valid = 1'b0;
    #1;
    check("pass_busy", 64'(bz), 64'(0));

    run_mul("basic", 32'd7, 32'd6, 1'b0, 33, 32'd42);
    post_idle("basic");

    // Reset in the middle of a multiply discards it.
    @(negedge clk);
    valid = 1'b1; code = MUL; d1 = 32'd1000; d2 = 32'd1000;
    @(negedge clk);
    valid = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("midrst_stall", 64'(st), 64'(0));
    check("midrst_busy", 64'(bz), 64'(0));
    check("midrst_valid", 64'(rv), 64'(0));
    check("midrst_result", 64'(rs), 64'(0));
    rst = 1'b1;
    run_mul("after_rst", 32'd7, 32'd6, 1'b0, 33, 32'd42);
    post_idle("after_rst");

    run_mul("isolate", 32'd123, 32'd456, 1'b1, 33, 32'd56088);
    post_idle("isolate");

    // Flush in the fifth RUN cycle.
    @(negedge clk);
    valid = 1'b1; code = MUL; d1 = 32'd100; d2 = 32'd3;
    @(negedge clk);
    valid = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_stall", 64'(st), 64'(0));
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_busy", 64'(bz), 64'(0));
    vcount = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (rv) vcount++;
    end
    check("flush_no_result", 64'(vcount), 64'(0));

    // ADD, then two MULs back to back.
    @(negedge clk);
    valid = 1'b1; code = ADD; d1 = 32'd3; d2 = 32'd5;
    #1;
    check("b2b_add_stall", 64'(st), 64'(0));
    run_mul("b2b_first", 32'd3, 32'd5, 1'b0, 33, 32'd15);
    run_mul("b2b_second", 32'd2, 32'd9, 1'b0, 33, 32'd18);
    post_idle("b2b");

    // Radix-16 instance.
    sel4 = 1'b1;
    run_mul("radix4", 32'hFFFF_FFFF, 32'h0000_0003, 1'b0, 9, 32'hFFFF_FFFD);
`ifdef MUL_SEQ_HI_EN
    check("radix4_hi", 64'(rh4), 64'(32'h0000_0002));
`endif
    post_idle("radix4");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
